// File: rtl/leds_arbiter.sv
// ============================================================================
// Module  : leds_arbiter
// Brief   : Tick-paced round-robin sharing of a 4-bit LED bank between
//           NUM_REQ pattern sources, with minimum hold and idle animation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module leds_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int COUNTER_WIDTH = 24,
    parameter int HOLD_TICKS    = 4,
    parameter int HOLD_WIDTH    = 8
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [4*NUM_REQ-1:0] PATTERN,
    input  logic [3:0]           IDLE_PATTERN,
    output logic [NUM_REQ-1:0]   GNT,
    output logic                 TICK,
    output logic                 BUSY,
    output logic [3:0]           DATA
);

    localparam int                    IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0]            ST_IDLE       = 1'b0;
    localparam logic [0:0]            ST_GRANT      = 1'b1;
    localparam logic [HOLD_WIDTH-1:0] C_HOLD_RELOAD = HOLD_WIDTH'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0]      C_PTR_RESET   = IDX_W'(NUM_REQ - 1);

    logic [COUNTER_WIDTH-1:0] cnt_q,   cnt_d;
    logic                     tick_q,  tick_d;
    logic [0:0]               state_q, state_d;
    logic [NUM_REQ-1:0]       gnt_q,   gnt_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [HOLD_WIDTH-1:0]    hold_q,  hold_d;
    logic [IDX_W-1:0]         ptr_q,   ptr_d;
    logic                     busy_q,  busy_d;
    logic [3:0]               data_q,  data_d;

    logic                     win_found;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         cand;
    logic [NUM_REQ-1:0]       win_onehot;
    logic [3:0]               owner_pattern;
    logic                     owner_req;

    // Scan starts just after the pointer, so the pointer itself is tried last.
    always_comb begin : p_pick
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin : p_decode
        win_onehot    = '0;
        owner_pattern = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_onehot[i] = 1'b1;
            end
            if (owner_q == IDX_W'(i)) begin
                owner_pattern = PATTERN[4*i +: 4];
            end
        end
    end

    assign owner_req = |(REQ & gnt_q);

    always_comb begin : p_next
        cnt_d   = cnt_q + COUNTER_WIDTH'(1);
        tick_d  = &cnt_q;
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        data_d  = (state_q == ST_GRANT) ? owner_pattern : IDLE_PATTERN;

        if (tick_q) begin
            if (state_q == ST_GRANT && owner_req && hold_q != '0) begin
                hold_d = hold_q - HOLD_WIDTH'(1);
            end else if (win_found) begin
                // Covers idle pickup, early release and hold expiry alike.
                state_d = ST_GRANT;
                gnt_d   = win_onehot;
                owner_d = win_idx;
                ptr_d   = win_idx;
                hold_d  = C_HOLD_RELOAD;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            ptr_q   <= C_PTR_RESET;
            busy_q  <= 1'b0;
            data_q  <= 4'b0000;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign GNT  = gnt_q;
    assign TICK = tick_q;
    assign BUSY = busy_q;
    assign DATA = data_q;

endmodule

`default_nettype wire

// File: tb/tb_leds_arbiter.sv
// ============================================================================
// Module  : tb_leds_arbiter
// Brief   : Self-checking bench for leds_arbiter (4 requesters, 16-cycle tick).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_leds_arbiter;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int HT  = 2;
    localparam int HW  = 8;
    localparam int PER = 16;
    localparam int IW  = 2;

    logic           clk     = 1'b0;
    logic           rstn    = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [4*N-1:0] pattern = '0;
    logic [3:0]     idle    = 4'b1100;
    logic [N-1:0]   gnt;
    logic           tick;
    logic           busy;
    logic [3:0]     data;

    int errors = 0;
    int checks = 0;

    // Reference: edges since release, current owner, ticks of hold left.
    int         m_edges = 0;
    bit         m_tick  = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_owner = 0;
    int         m_hold  = 0;
    int         m_last  = N - 1;
    logic [3:0] m_data  = 4'b0000;

    always #5 clk = ~clk;

    leds_arbiter #(
        .NUM_REQ      (N),
        .COUNTER_WIDTH(CW),
        .HOLD_TICKS   (HT),
        .HOLD_WIDTH   (HW)
    ) dut (
        .CLK         (clk),
        .RSTN        (rstn),
        .REQ         (req),
        .PATTERN     (pattern),
        .IDLE_PATTERN(idle),
        .GNT         (gnt),
        .TICK        (tick),
        .BUSY        (busy),
        .DATA        (data)
    );

    function automatic logic [N-1:0] exp_gnt();
        return m_busy ? (N'(1) << m_owner) : '0;
    endfunction

    function automatic int pick(int from, logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (r[c[IW-1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic int gnt_index(logic [N-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (g == (N'(1) << k)) return k;
        end
        return -1;
    endfunction

    // One clock: advance the reference from the inputs seen at the edge.
    task automatic step();
        logic [3:0] nd;
        int         w;
        @(posedge clk);
        if (!rstn) begin
            m_edges = 0;
            m_tick  = 1'b0;
            m_busy  = 1'b0;
            m_owner = 0;
            m_hold  = 0;
            m_last  = N - 1;
            m_data  = 4'b0000;
        end else begin
            nd = m_busy ? 4'(pattern >> (4 * m_owner)) : idle;
            if (m_tick) begin
                if (m_busy && req[m_owner[IW-1:0]] && m_hold > 0) begin
                    m_hold = m_hold - 1;
                end else begin
                    w = pick(m_last, req);
                    if (w < 0) begin
                        m_busy = 1'b0;
                        m_hold = 0;
                    end else begin
                        m_busy  = 1'b1;
                        m_owner = w;
                        m_hold  = HT - 1;
                        m_last  = w;
                    end
                end
            end
            m_data  = nd;
            m_edges = m_edges + 1;
            m_tick  = (m_edges % PER) == 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        req  = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        req     = '0;
        idle    = 4'b1100;
        pattern = 16'($urandom);
        repeat (3) step();
        checks++;
        if ({gnt, busy, data, tick} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b busy=%b data=%b tick=%b, expected all zero", gnt, busy, data, tick);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (data !== 4'b1100 || gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: data=%b gnt=%b busy=%b, expected data=1100 gnt=0000 busy=0", data, gnt, busy);
        end
        for (int e = 2; e <= 2 * PER + 1; e++) begin
            step();
            checks++;
            if (tick !== ((e % PER) == 0) || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL tick_period edge%0d: tick=%b gnt=%b, expected tick=%b gnt=0000", e, tick, gnt, (e % PER) == 0);
            end
        end
    endtask

    task automatic test_single_req();
        bit pre;
        bit seen = 1'b0;
        apply_reset();
        repeat (5) step();
        pattern[3:0] = 4'hA;
        req          = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            pre = tick;
            step();
            if (pre) begin
                seen = 1'b1;
                break;
            end
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL single_frozen: gnt=%b before tick, expected 0000", gnt);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_timeout: no tick within 40 cycles");
        end
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || data !== 4'b1100) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b data=%h, expected gnt=0001 busy=1 data=c", gnt, busy, data);
        end
        step();
        checks++;
        if (data !== 4'hA) begin
            errors++;
            $display("FAIL single_data: data=%h, expected a", data);
        end
        for (int k = 0; k < 5 * PER; k++) begin
            if (k == 20) pattern[3:0] = 4'h5;
            step();
            checks++;
            if (gnt !== 4'b0001 || data !== ((k >= 20) ? 4'h5 : 4'hA)) begin
                errors++;
                $display("FAIL single_hold cyc%0d: gnt=%b data=%h, expected gnt=0001 data=%h", k, gnt, data, (k >= 20) ? 4'h5 : 4'hA);
            end
        end
    endtask

    task automatic test_round_robin();
        int             order[$];
        int             at[$];
        logic [N-1:0]   prev = '0;
        int             exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        pattern = 16'($urandom);
        req     = 4'b1111;
        for (int e = 1; e <= 150; e++) begin
            step();
            checks++;
            if ({gnt, busy, data, tick} !== {exp_gnt(), m_busy, m_data, m_tick}) begin
                errors++;
                $display("FAIL rr_model edge%0d: gnt=%b busy=%b data=%h tick=%b, expected gnt=%b busy=%b data=%h tick=%b",
                         e, gnt, busy, data, tick, exp_gnt(), m_busy, m_data, m_tick);
            end
            if (e >= 17) begin
                checks++;
                if (!$onehot(gnt)) begin
                    errors++;
                    $display("FAIL rr_onehot edge%0d: gnt=%b, expected exactly one bit", e, gnt);
                end
            end
            if (gnt != prev && gnt != '0) begin
                order.push_back(gnt_index(gnt));
                at.push_back(e);
            end
            prev = gnt;
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL rr_count: %0d grant changes, expected 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i] || at[i] != 17 + 32 * i) begin
                    errors++;
                    $display("FAIL rr_order %0d: owner=%0d at edge %0d, expected owner=%0d at edge %0d",
                             i, order[i], at[i], exp_order[i], 17 + 32 * i);
                end
            end
        end
    endtask

    task automatic test_early_release();
        bit pre;
        bit seen = 1'b0;
        apply_reset();
        pattern = 16'($urandom);
        req     = 4'b0010;
        for (int k = 0; k < 40 && gnt == '0; k++) step();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL early_first: gnt=%b, expected 0010", gnt);
        end
        step();
        req = 4'b0100;
        for (int k = 0; k < 40; k++) begin
            pre = tick;
            step();
            if (pre) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || gnt !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_release: gnt=%b busy=%b tick_seen=%b, expected gnt=0100 busy=1 tick_seen=1", gnt, busy, seen);
        end
    endtask

    task automatic test_idle_return();
        bit pre;
        bit seen = 1'b0;
        idle = 4'($urandom);
        req  = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            pre = tick;
            step();
            if (pre) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || gnt !== 4'b0000 || busy !== 1'b0 || data !== pattern[11:8]) begin
            errors++;
            $display("FAIL idle_drop: gnt=%b busy=%b data=%h tick_seen=%b, expected gnt=0000 busy=0 data=%h tick_seen=1",
                     gnt, busy, data, seen, pattern[11:8]);
        end
        step();
        checks++;
        if (data !== idle) begin
            errors++;
            $display("FAIL idle_data: data=%h, expected %h", data, idle);
        end
    endtask

    task automatic test_reset_mid_grant();
        bit pre;
        int e    = 0;
        bit seen = 1'b0;
        apply_reset();
        pattern = 16'($urandom);
        req     = 4'b0001;
        for (int k = 0; k < 40 && gnt == '0; k++) step();
        req = 4'b0011;
        repeat (3) step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_pre: gnt=%b, expected 0001", gnt);
        end
        rstn = 1'b0;
        step();
        checks++;
        if ({gnt, busy, data, tick} !== 10'b0) begin
            errors++;
            $display("FAIL midreset_state: gnt=%b busy=%b data=%b tick=%b, expected all zero", gnt, busy, data, tick);
        end
        rstn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            pre = tick;
            step();
            e++;
            if (pre) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || e != PER + 1 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_rewin: gnt=%b grant_edge=%0d, expected gnt=0001 grant_edge=%0d", gnt, e, PER + 1);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0)   req     = 4'($urandom);
            if ($urandom_range(0, 5) == 0)   pattern = 16'($urandom);
            if ($urandom_range(0, 31) == 0)  idle    = 4'($urandom);
            rstn = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if ({gnt, busy, data, tick} !== {exp_gnt(), m_busy, m_data, m_tick}) begin
                errors++;
                $display("FAIL random cyc%0d: gnt=%b busy=%b data=%h tick=%b, expected gnt=%b busy=%b data=%h tick=%b",
                         c, gnt, busy, data, tick, exp_gnt(), m_busy, m_data, m_tick);
            end
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_early_release();
        test_idle_return();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
